// File: rtl/core_oam_dma.sv
// Sprite DMA controller sitting between the 6502 core bus and the system bus.
// In IDLE the core bus passes straight through. A core write to the trigger
// address freezes the core through its ready input and copies one 256-byte
// page to the OAM data port, one read plus one write per byte. An optional
// alignment cycle makes every read land on an even bus cycle, which gives
// the 513/514-cycle stall the original console shows.
//
// Handshake: O_cpu_ready is a plain level towards the core. While it is 0 the
// core holds its bus outputs and O_active marks that the DMA owns the bus.
// Both are registered and change only at the end of a bus cycle, which is
// the falling edge of I_phy2 as seen in the I_clock domain. An asynchronous
// reset clears them at once.
module core_oam_dma #(
    parameter logic [15:0] P_TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] P_OAM_ADDR     = 16'h2004
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_phy2,
    input  logic [15:0] I_cpu_addr,
    input  logic [7:0]  I_cpu_wr_data,
    input  logic        I_cpu_rdwr,
    output logic        O_cpu_ready,
    output logic [7:0]  O_cpu_rd_data,
    output logic [15:0] O_addr,
    output logic [7:0]  O_wr_data,
    output logic        O_rdwr,
    input  logic [7:0]  I_rd_data,
    output logic        O_active
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    state_t      state;
    logic [7:0]  page;
    logic [7:0]  idx;
    logic [7:0]  data;
    logic        last_phy2;
    logic        parity;
    logic        cyc_end;
    logic        trigger_hit;

    // A bus cycle ends on the falling edge of phase 2.
    assign cyc_end = last_phy2 & ~I_phy2;

    // A core write to the trigger address; reads and other addresses do nothing.
    assign trigger_hit = (I_cpu_rdwr == 1'b0) && (I_cpu_addr == P_TRIGGER_ADDR);

    // Read data always flows straight back to the core.
    assign O_cpu_rd_data = I_rd_data;

    // Phase-2 edge detector and bus-cycle parity. Parity 0 marks an even cycle.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            last_phy2 <= 1'b0;
            parity    <= 1'b0;
        end else begin
            last_phy2 <= I_phy2;
            if (cyc_end) begin
                parity <= ~parity;
            end
        end
    end

    // Transfer sequencer; every state change happens at the end of a bus cycle.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            state       <= ST_IDLE;
            page        <= 8'h00;
            idx         <= 8'h00;
            data        <= 8'h00;
            O_cpu_ready <= 1'b1;
            O_active    <= 1'b0;
        end else if (cyc_end) begin
            case (state)
                ST_IDLE: begin
                    if (trigger_hit) begin
                        page        <= I_cpu_wr_data;
                        idx         <= 8'h00;
                        state       <= ST_HALT;
                        O_cpu_ready <= 1'b0;
                        O_active    <= 1'b1;
                    end
                end
                ST_HALT: begin
                    // Even HALT means the next cycle is odd: burn one more so
                    // every READ starts on an even cycle.
                    if (parity == 1'b0) begin
                        state <= ST_ALIGN;
                    end else begin
                        state <= ST_READ;
                    end
                end
                ST_ALIGN: begin
                    state <= ST_READ;
                end
                ST_READ: begin
                    data  <= I_rd_data;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    idx <= idx + 8'd1;
                    if (idx == 8'hFF) begin
                        state       <= ST_IDLE;
                        O_cpu_ready <= 1'b1;
                        O_active    <= 1'b0;
                    end else begin
                        state <= ST_READ;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    O_cpu_ready <= 1'b1;
                    O_active    <= 1'b0;
                end
            endcase
        end
    end

    // Bus ownership: the core in IDLE, dummy reads of the frozen core address
    // in HALT/ALIGN, then alternating source reads and OAM writes.
    always_comb begin
        O_addr    = I_cpu_addr;
        O_wr_data = I_cpu_wr_data;
        O_rdwr    = I_cpu_rdwr;
        case (state)
            ST_IDLE: begin
                O_addr    = I_cpu_addr;
                O_wr_data = I_cpu_wr_data;
                O_rdwr    = I_cpu_rdwr;
            end
            ST_HALT, ST_ALIGN: begin
                O_addr    = I_cpu_addr;
                O_wr_data = I_cpu_wr_data;
                O_rdwr    = 1'b1;
            end
            ST_READ: begin
                O_addr    = {page, idx};
                O_wr_data = data;
                O_rdwr    = 1'b1;
            end
            ST_WRITE: begin
                O_addr    = P_OAM_ADDR;
                O_wr_data = data;
                O_rdwr    = 1'b0;
            end
            default: begin
                O_addr    = I_cpu_addr;
                O_wr_data = I_cpu_wr_data;
                O_rdwr    = I_cpu_rdwr;
            end
        endcase
    end

endmodule

// File: tb/tb_core_oam_dma.sv
// Directed bench for core_oam_dma: pass-through, even/odd DMA starts, data
// integrity, page $FF, non-triggers and reset in the middle of a transfer.
module tb_core_oam_dma;

    logic        I_clock;
    logic        I_reset;
    logic        I_phy2;
    logic [15:0] I_cpu_addr;
    logic [7:0]  I_cpu_wr_data;
    logic        I_cpu_rdwr;
    logic        O_cpu_ready;
    logic [7:0]  O_cpu_rd_data;
    logic [15:0] O_addr;
    logic [7:0]  O_wr_data;
    logic        O_rdwr;
    logic [7:0]  I_rd_data;
    logic        O_active;

    core_oam_dma dut (
        .I_clock       (I_clock),
        .I_reset       (I_reset),
        .I_phy2        (I_phy2),
        .I_cpu_addr    (I_cpu_addr),
        .I_cpu_wr_data (I_cpu_wr_data),
        .I_cpu_rdwr    (I_cpu_rdwr),
        .O_cpu_ready   (O_cpu_ready),
        .O_cpu_rd_data (O_cpu_rd_data),
        .O_addr        (O_addr),
        .O_wr_data     (O_wr_data),
        .O_rdwr        (O_rdwr),
        .I_rd_data     (I_rd_data),
        .O_active      (O_active)
    );

    // clock / memory model
    initial I_clock = 1'b0;
    always #5 I_clock = ~I_clock;

    logic [7:0] mem [0:65535];
    assign I_rd_data = mem[O_addr];

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc_n     = 0;

    logic [15:0] s_addr;
    logic [7:0]  s_wdata;
    logic        s_rdwr;
    logic        s_ready;
    logic        s_active;
    logic        s_par;
    logic [7:0]  s_rd;

    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];

    int          stall;
    int          dummies;
    int          first_par;
    logic [15:0] first_rd;
    logic [15:0] last_rd;
    int          bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        I_reset       = 1'b0;
        I_phy2        = 1'b0;
        I_cpu_addr    = 16'h8000;
        I_cpu_wr_data = 8'h00;
        I_cpu_rdwr    = 1'b1;
        repeat (2) @(posedge I_clock);
        #1;
        I_reset = 1'b1;
        cyc_n   = 0;
    endtask

    // One core bus cycle: phy2 high for a clock, then low; sampled in the low phase.
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
        I_cpu_addr    = a;
        I_cpu_wr_data = d;
        I_cpu_rdwr    = rw;
        I_phy2        = 1'b1;
        @(posedge I_clock);
        #1;
        I_phy2   = 1'b0;
        s_addr   = O_addr;
        s_wdata  = O_wr_data;
        s_rdwr   = O_rdwr;
        s_ready  = O_cpu_ready;
        s_active = O_active;
        s_rd     = O_cpu_rd_data;
        s_par    = cyc_n[0];
        @(posedge I_clock);
        #1;
        cyc_n++;
    endtask

    // Run the core frozen at $8123 until ready returns, recording DMA traffic.
    task automatic run_dma();
        stall     = 0;
        dummies   = 0;
        first_par = -1;
        first_rd  = 16'h0000;
        last_rd   = 16'h0000;
        wa_q.delete();
        wd_q.delete();
        for (int k = 0; k < 600; k++) begin
            bus_cycle(16'h8123, 8'h00, 1'b1);
            if (s_ready) break;
            stall++;
            if (s_rdwr && s_addr == 16'h8123) begin
                dummies++;
            end else if (s_rdwr) begin
                if (first_par < 0) begin
                    first_par = int'(s_par);
                    first_rd  = s_addr;
                end
                last_rd = s_addr;
            end else begin
                wa_q.push_back(s_addr);
                wd_q.push_back(s_wdata);
            end
        end
    endtask

    // Every recorded write must be to $2004 with mem[page:i] in order.
    task automatic check_writes(input string tag, input logic [7:0] pg);
        chk({tag, "_nwrites"}, wa_q.size(), 256);
        bad = 0;
        for (int i = 0; i < wa_q.size() && i < 256; i++) begin
            if (wa_q[i] !== 16'h2004 || wd_q[i] !== mem[{pg, i[7:0]}]) bad++;
        end
        chk({tag, "_write_errs"}, bad, 0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = i[7:0] ^ i[15:8] ^ 8'h3C;
        for (int i = 0; i < 256; i++) mem[16'h0700 + i] = i[7:0] ^ 8'hA5;
        mem[16'h02FF] = 8'h5E;

        // reset state
        do_reset();
        #1;
        chk("rst_ready", O_cpu_ready, 1);
        chk("rst_active", O_active, 0);
        chk("rst_addr_pass", O_addr, 16'h8000);
        chk("rst_rdwr_pass", O_rdwr, 1);

        // pass-through
        bus_cycle(16'h8000, 8'h00, 1'b1);
        chk("pt_rd_addr", s_addr, 16'h8000);
        chk("pt_rd_rdwr", s_rdwr, 1);
        chk("pt_rd_data", s_rd, mem[16'h8000]);
        chk("pt_rd_ready", s_ready, 1);
        bus_cycle(16'h0300, 8'h55, 1'b0);
        chk("pt_wr_addr", s_addr, 16'h0300);
        chk("pt_wr_data", s_wdata, 8'h55);
        chk("pt_wr_rdwr", s_rdwr, 0);
        chk("pt_wr_ready", s_ready, 1);

        // non-triggers
        bus_cycle(16'h4014, 8'h07, 1'b1);
        bus_cycle(16'h4015, 8'h07, 1'b0);
        chk("nt_wr_pass", s_addr, 16'h4015);
        bus_cycle(16'h8000, 8'h00, 1'b1);
        chk("nt_active", s_active, 0);
        chk("nt_ready", s_ready, 1);

        // even-start DMA: trigger in cycle 0, HALT in cycle 1 (parity 1)
        do_reset();
        bus_cycle(16'h4014, 8'h02, 1'b0);
        chk("ev_trig_pass_addr", s_addr, 16'h4014);
        chk("ev_trig_pass_data", s_wdata, 8'h02);
        chk("ev_trig_ready", s_ready, 1);
        run_dma();
        chk("ev_stall", stall, 513);
        chk("ev_dummies", dummies, 1);
        chk("ev_first_rd", first_rd, 16'h0200);
        chk("ev_last_rd", last_rd, 16'h02FF);
        chk("ev_first_par", first_par, 0);
        chk("ev_last_data", wd_q.size() > 0 ? wd_q[wd_q.size() - 1] : 8'hxx, 8'h5E);
        check_writes("ev", 8'h02);
        chk("ev_after_active", s_active, 0);
        chk("ev_after_pass", s_addr, 16'h8123);

        // odd-start DMA: trigger in cycle 1, HALT in cycle 2 (parity 0)
        do_reset();
        bus_cycle(16'h8000, 8'h00, 1'b1);
        bus_cycle(16'h4014, 8'h07, 1'b0);
        run_dma();
        chk("od_stall", stall, 514);
        chk("od_dummies", dummies, 2);
        chk("od_first_par", first_par, 0);
        chk("od_first_rd", first_rd, 16'h0700);
        chk("od_data0", wd_q.size() > 1 ? {wd_q[0], wd_q[1]} : 16'hxxxx, 16'hA5A4);
        check_writes("od", 8'h07);

        // page $FF source, no wrap
        do_reset();
        bus_cycle(16'h4014, 8'hFF, 1'b0);
        run_dma();
        chk("ff_stall", stall, 513);
        chk("ff_first_rd", first_rd, 16'hFF00);
        chk("ff_last_rd", last_rd, 16'hFFFF);
        check_writes("ff", 8'hFF);

        // reset in the middle of a transfer (after the READ of idx $40)
        do_reset();
        bus_cycle(16'h4014, 8'h03, 1'b0);
        bad = 1;
        for (int k = 0; k < 300; k++) begin
            bus_cycle(16'h8123, 8'h00, 1'b1);
            if (s_rdwr && s_addr == 16'h0340) begin
                bad = 0;
                break;
            end
        end
        chk("mr_reached_idx40", bad, 0);
        chk("mr_active_before", O_active, 1);
        I_cpu_addr = 16'h9000;
        I_cpu_rdwr = 1'b1;
        I_reset    = 1'b0;
        #1;
        chk("mr_ready", O_cpu_ready, 1);
        chk("mr_active", O_active, 0);
        chk("mr_addr_pass", O_addr, 16'h9000);
        chk("mr_rdwr_pass", O_rdwr, 1);
        @(posedge I_clock);
        #1;
        I_reset = 1'b1;
        cyc_n   = 0;
        bus_cycle(16'h0123, 8'h99, 1'b0);
        chk("mr_post_pass_addr", s_addr, 16'h0123);
        chk("mr_post_pass_rdwr", s_rdwr, 0);
        bus_cycle(16'h4014, 8'h04, 1'b0);
        run_dma();
        chk("mr_stall", stall, 514);
        chk("mr_first_rd", first_rd, 16'h0400);
        check_writes("mr", 8'h04);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
